// File: rtl/enemy_bullet_handle.sv
// Enemy projectile engine: one downward bullet with launch cooldown, player hit detection and pixel render.
// Define ENEMY_BULLET_AIM_EN to steer the bullet X one pixel per move tick toward the player centre.
module enemy_bullet_handle #(
  parameter int MOVE_DIV      = 200000,
  parameter int STEP          = 2,
  parameter int COOLDOWN      = 60,
  parameter int SCREEN_BOTTOM = 479,
  parameter int PLAYER_Y      = 440,
  parameter int PLAYER_W      = 32,
  parameter int BULLET_LEN    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] enemyPosX,
  input  logic [9:0] enemyPosY,
  input  logic [9:0] playerPos,
  input  logic [9:0] horCnt,
  input  logic [9:0] verCnt,
  output logic [9:0] bulletPosX,
  output logic [9:0] bulletPosY,
  output logic       bulletActive,
  output logic       playerHit,
  output logic [5:0] rgbContent
);

  localparam int DIV_W = $clog2(MOVE_DIV);
  localparam int CD_W  = $clog2(COOLDOWN + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT} state_t;

  state_t            r_state, w_state_n;
  logic [DIV_W-1:0]  r_div;
  logic [CD_W-1:0]   r_cool, w_cool_n;
  logic [9:0]        r_x, r_y, w_x_n, w_y_n, w_aim_x;
  logic [10:0]       w_ny;
  logic [5:0]        r_rgb;
  logic              w_tick, w_hit, w_draw;

  assign w_tick = enable && (r_div == DIV_W'(MOVE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable || w_tick) r_div <= '0;
    else                            r_div <= r_div + 1'b1;
  end

  // Candidate move for this tick; X steering only exists in the aiming build
  always_comb begin
    w_ny    = {1'b0, r_y} + 11'(STEP);
    w_aim_x = r_x;
`ifdef ENEMY_BULLET_AIM_EN
    if ({1'b0, r_x} < ({1'b0, playerPos} + 11'(PLAYER_W / 2)))
      w_aim_x = (r_x >= 10'd639) ? 10'd639 : r_x + 10'd1;
    else if ({1'b0, r_x} > ({1'b0, playerPos} + 11'(PLAYER_W / 2)))
      w_aim_x = (r_x == 10'd0) ? 10'd0 : r_x - 10'd1;
`endif
    w_hit = ((w_ny + 11'(BULLET_LEN - 1)) >= 11'(PLAYER_Y)) &&
            ({1'b0, playerPos} <= {1'b0, w_aim_x}) &&
            ({1'b0, w_aim_x} <= ({1'b0, playerPos} + 11'(PLAYER_W - 1)));
  end

  always_comb begin
    w_state_n = r_state;
    w_cool_n  = r_cool;
    w_x_n     = r_x;
    w_y_n     = r_y;
    if (!enable) begin
      w_state_n = S_IDLE;
      w_cool_n  = CD_W'(COOLDOWN);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cool == '0) begin
            w_x_n     = enemyPosX;
            w_y_n     = enemyPosY + 10'd1;
            w_state_n = S_FLY;
          end else if (w_tick) begin
            w_cool_n = r_cool - 1'b1;
          end
        end
        S_FLY: begin
          if (w_tick) begin
            w_x_n = w_aim_x;
            // A hit on the last visible step wins over leaving the screen
            if (w_hit) begin
              w_y_n     = w_ny[9:0];
              w_state_n = S_HIT;
            end else if (w_ny > 11'(SCREEN_BOTTOM)) begin
              w_state_n = S_IDLE;
              w_cool_n  = CD_W'(COOLDOWN);
            end else begin
              w_y_n = w_ny[9:0];
            end
          end
        end
        S_HIT: begin
          w_state_n = S_IDLE;
          w_cool_n  = CD_W'(COOLDOWN);
        end
        default: begin
          w_state_n = S_IDLE;
          w_cool_n  = CD_W'(COOLDOWN);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cool  <= CD_W'(COOLDOWN);
      r_x     <= 10'd319;
      r_y     <= 10'd0;
    end else begin
      r_state <= w_state_n;
      r_cool  <= w_cool_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
    end
  end

  assign w_draw = (r_state == S_FLY) &&
                  (verCnt >= r_y) && ({1'b0, verCnt} <= ({1'b0, r_y} + 11'(BULLET_LEN - 1))) &&
                  (horCnt >= r_x) && ({1'b0, horCnt} <= ({1'b0, r_x} + 11'd1));

  always_ff @(posedge clk) begin
    if (reset) r_rgb <= 6'b000000;
    else       r_rgb <= w_draw ? 6'b110000 : 6'b000000;
  end

  assign bulletPosX   = r_x;
  assign bulletPosY   = r_y;
  assign bulletActive = (r_state == S_FLY);
  assign playerHit    = (r_state == S_HIT);
  assign rgbContent   = r_rgb;

endmodule

// File: doc/enemy_bullet_handle.md
# enemy_bullet_handle

Downward-travelling enemy projectile engine: the opposite direction of the player shot path. Launches one bullet from the current enemy muzzle position, steps it toward the bottom of the 640x480 field on a divided move tick, and detects a hit against the player sprite row. Emits a one-cycle `playerHit` pulse to the game-state logic and a 6-bit pixel colour for the VGA mixer alongside the player-bullet layer.

## Interface
Parameters:
- `MOVE_DIV`, 200000 — clk cycles per move tick (≥2)
- `STEP`, 2 — pixels moved per tick
- `COOLDOWN`, 60 — move ticks spent in IDLE between shots
- `SCREEN_BOTTOM`, 479 — last visible line
- `PLAYER_Y`, 440 — top line of the player sprite
- `PLAYER_W`, 32 — player sprite width in pixels
- `BULLET_LEN`, 16 — bullet height in lines

Ports:
- `clk` in 1 — pixel/system clock
- `reset` in 1 — synchronous, active-high
- `enable` in 1 — game running; low aborts/holds the block
- `enemyPosX` in 10 — muzzle X of the firing enemy
- `enemyPosY` in 10 — bottom line of the firing enemy
- `playerPos` in 10 — player sprite left X
- `horCnt` in 10, `verCnt` in 10 — VGA scan counters
- `bulletPosX` out 10, `bulletPosY` out 10 — bullet top-left
- `bulletActive` out 1 — bullet in flight
- `playerHit` out 1 — one-cycle hit pulse
- `rgbContent` out 6 — bullet pixel colour, 0 when not drawn

## Operation
- Tick divider: counts 0..MOVE_DIV-1, `tick` = 1-cycle pulse at MOVE_DIV-1, free-running whenever `enable`=1; cleared to 0 by reset.
- FSM states IDLE, FLY, HIT.
- IDLE: `bulletActive`=0. On each tick, cooldown decrements if nonzero. When cooldown=0 and `enable`=1: latch X=`enemyPosX`, Y=`enemyPosY`+1, go FLY.
- FLY: `bulletActive`=1. On tick compute nextY = Y+STEP in 11 bits (no wrap). Hit condition: nextY+BULLET_LEN-1 ≥ PLAYER_Y and playerPos ≤ X ≤ playerPos+PLAYER_W-1 (11-bit compare). Hit → Y=nextY, go HIT. Else nextY > SCREEN_BOTTOM → go IDLE, reload cooldown. Else Y=nextY. Hit has priority over off-screen.
- HIT: `playerHit`=1 for exactly this one cycle; `bulletActive`=0; reload cooldown; go IDLE next cycle.
- `enable`=0 in any state: next state IDLE, `bulletActive`=0, cooldown reloaded, `playerHit` not asserted, divider held at 0.
- Render: when `bulletActive`, `verCnt` in [Y, Y+BULLET_LEN-1] and `horCnt` in [X, X+1] → `rgbContent`=6'b110000, else 6'b000000.

## Timing
- Reset values: `bulletPosX`=319, `bulletPosY`=0, `bulletActive`=0, `playerHit`=0, `rgbContent`=0, state IDLE, cooldown=COOLDOWN, divider=0.
- Reset mid-flight: all of the above on the next edge; no hit pulse.
- Launch: FSM enters FLY on the cycle after the tick that brings cooldown to 0 is followed by a cycle with cooldown=0; position latched on the IDLE→FLY edge; `bulletActive` high that same edge.
- Position update registered on the tick edge; `playerHit` high the cycle after the hitting tick, low the following cycle.
- `rgbContent` registered: 1-cycle latency from `horCnt`/`verCnt`.
- Inputs `enemyPosX`/`enemyPosY` sampled only at launch; `playerPos` sampled at every FLY tick.

## Configuration
- `ENEMY_BULLET_AIM_EN` defined: in FLY, each tick X also moves 1 pixel toward playerPos+PLAYER_W/2 (no move if equal); X saturates at 0 and 639. Hit test uses the updated X.
- Undefined: X is constant for the whole flight.

## Test plan
(Bench params MOVE_DIV=4, STEP=2, COOLDOWN=3, PLAYER_Y=440, PLAYER_W=32.)
- Reset, `enable`=1, enemyPosX=100, enemyPosY=50 → after 3 ticks in IDLE, FLY with X=100, Y=51; Y=53 after the next tick.
- Launch from enemyPosY=420, playerPos=90 → hit when nextY+15 ≥ 440 (Y=425); one-cycle `playerHit`, `bulletActive`=0, back to IDLE.
- Same launch with playerPos=200 → no hit; bullet leaves after Y>479, no `playerHit`, cooldown restarts at 3.
- `enable` dropped mid-flight at Y=200 → `bulletActive`=0 next cycle, no pulse; relaunch 3 ticks after re-enable.
- Scan verCnt=60, horCnt=100/101/102 with Y=51, X=100 → rgbContent 6'b110000, 6'b110000, 0 one cycle later.
- With `ENEMY_BULLET_AIM_EN`, X=100, playerPos=200 → X increments by 1 per tick (101, 102, …) until 216.
